// File: rtl/ring_counter_sched.sv
// Command-driven sequencer for an 8-bit ring counter: turns LOAD / SET_DIV / BURST / RUNSTOP
// commands into step, direction and parallel-load strobes, with a programmable prescaler.
module ring_counter_sched #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic             cmd_ready,
  input  logic             pause,
  output logic             ring_en,
  output logic             ring_dir,
  output logic             ring_load,
  output logic [WIDTH-1:0] ring_load_val,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] OP_LOAD    = 2'b00;
  localparam logic [1:0] OP_SET_DIV = 2'b01;
  localparam logic [1:0] OP_BURST   = 2'b10;
  localparam logic [1:0] OP_RUNSTOP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BURST,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic               dir_q, dir_d;
  logic [WIDTH-1:0]   loadVal_q, loadVal_d;
  logic               err_q, err_d;

  logic accept;
  logic stepHit;
  logic stepping;

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign stepHit   = (presc_q == div_q);
  assign stepping  = (state_q == S_BURST) || (state_q == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      presc_q   <= '0;
      remain_q  <= '0;
      dir_q     <= 1'b0;
      loadVal_q <= WIDTH'(1);
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      presc_q   <= presc_d;
      remain_q  <= remain_d;
      dir_q     <= dir_d;
      loadVal_q <= loadVal_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    presc_d   = presc_q;
    remain_d  = remain_q;
    dir_d     = dir_q;
    loadVal_d = loadVal_q;
    err_d     = err_q;

    case (state_q)
      S_LOAD:  state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      S_RUN: begin
        if (!pause) presc_d = stepHit ? '0 : presc_q + 1'b1;
      end
      S_BURST: begin
        if (!pause) begin
          if (stepHit) begin
            presc_d  = '0;
            remain_d = remain_q - 1'b1;
            if (remain_q == CNT_W'(1)) state_d = S_DONE;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Commands are only accepted in IDLE, RUN and DONE, so they safely override the above.
    if (accept) begin
      err_d = 1'b0;
      case (cmd_op)
        OP_LOAD: begin
          if (cmd_arg == '0) begin
            loadVal_d = WIDTH'(1);
            err_d     = 1'b1;
          end else begin
            loadVal_d = cmd_arg;
          end
          state_d = S_LOAD;
        end
        OP_SET_DIV: begin
          div_d   = cmd_arg[DIV_W-1:0];
          presc_d = '0;
          state_d = (state_q == S_RUN) ? S_RUN : S_IDLE;
        end
        OP_BURST: begin
          dir_d    = cmd_arg[WIDTH-1];
          remain_d = cmd_arg[CNT_W-1:0];
          presc_d  = '0;
          state_d  = (cmd_arg[CNT_W-1:0] == '0) ? S_DONE : S_BURST;
        end
        OP_RUNSTOP: begin
          if (cmd_arg[0]) begin
            dir_d   = cmd_arg[1];
            presc_d = '0;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // pause gates the step strobe within the same cycle so a paused cycle can never step.
  assign ring_en       = stepping && stepHit && !pause;
  assign ring_dir      = dir_q;
  assign ring_load     = (state_q == S_LOAD);
  assign ring_load_val = loadVal_q;
  assign busy          = (state_q == S_LOAD) || stepping;
  assign done          = (state_q == S_DONE);
  assign err           = err_q;

endmodule

// File: tb/tb_ring_counter_sched.sv
// Directed self-checking bench for ring_counter_sched; per-cycle strobes are gathered into
// bit vectors indexed by cycle offset from the accept edge and compared to hand-built masks.
module tb_ring_counter_sched;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       cmd_ready;
  logic       pause;
  logic       ring_en;
  logic       ring_dir;
  logic       ring_load;
  logic [7:0] ring_load_val;
  logic       busy;
  logic       done;
  logic       err;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] enVec, doneVec, readyVec, busyVec;

  ring_counter_sched #(.WIDTH(8), .DIV_W(8), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_ready(cmd_ready), .pause(pause), .ring_en(ring_en), .ring_dir(ring_dir),
    .ring_load(ring_load), .ring_load_val(ring_load_val), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Returns just after the accept edge, i.e. at the start of cycle k+1.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] arg);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) checkOutput("readyTimeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic collect(input int cycles);
    enVec = '0; doneVec = '0; readyVec = '0; busyVec = '0;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      enVec[c]    = ring_en;
      doneVec[c]  = done;
      readyVec[c] = cmd_ready;
      busyVec[c]  = busy;
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 8'h00; pause = 1'b0;
    $display("[TB] reset state");
    @(negedge clk);
    checkOutput("rstEn",      32'(ring_en),       32'd0);
    checkOutput("rstLoad",    32'(ring_load),     32'd0);
    checkOutput("rstLoadVal", 32'(ring_load_val), 32'h01);
    checkOutput("rstBusy",    32'(busy),          32'd0);
    checkOutput("rstDone",    32'(done),          32'd0);
    checkOutput("rstErr",     32'(err),           32'd0);
    checkOutput("rstReady",   32'(cmd_ready),     32'd1);
    checkOutput("rstDir",     32'(ring_dir),      32'd0);
    rst_n = 1'b1;

    $display("[TB] LOAD 0x81");
    applyStimulus(2'b00, 8'h81);
    @(negedge clk);
    checkOutput("loadStrobe", 32'(ring_load),     32'd1);
    checkOutput("loadVal",    32'(ring_load_val), 32'h81);
    checkOutput("loadErr",    32'(err),           32'd0);
    checkOutput("loadReady",  32'(cmd_ready),     32'd0);
    @(negedge clk);
    checkOutput("loadEnd",    32'(ring_load),     32'd0);
    checkOutput("loadBusy",   32'(busy),          32'd0);
    checkOutput("loadReady2", 32'(cmd_ready),     32'd1);

    $display("[TB] SET_DIV 3, BURST 0x85");
    applyStimulus(2'b01, 8'h03);
    applyStimulus(2'b10, 8'h85);
    collect(24);
    checkOutput("burstDir",   32'(ring_dir), 32'd1);
    checkOutput("burstEn",    enVec,    32'h0011_1110);
    checkOutput("burstDone",  doneVec,  32'h0020_0000);
    checkOutput("burstReady", readyVec, 32'h01E0_0000);
    checkOutput("burstBusy",  busyVec,  32'h001F_FFFE);

    $display("[TB] BURST 0x00");
    applyStimulus(2'b10, 8'h00);
    collect(4);
    checkOutput("zeroBurstEn",   enVec,   32'h0);
    checkOutput("zeroBurstDone", doneVec, 32'h2);

    $display("[TB] RUN with div 0 and pause");
    applyStimulus(2'b01, 8'h00);
    applyStimulus(2'b11, 8'h01);
    enVec = '0; busyVec = '0; readyVec = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      enVec[c]    = ring_en;
      busyVec[c]  = busy;
      readyVec[c] = cmd_ready;
      @(posedge clk);
      #1 pause = (c + 1 >= 4) && (c + 1 <= 6);
    end
    pause = 1'b0;
    checkOutput("runEn",    enVec,    32'h0000_1F8E);
    checkOutput("runBusy",  busyVec,  32'h0000_1FFE);
    checkOutput("runReady", readyVec, 32'h0000_1FFE);
    checkOutput("runDir",   32'(ring_dir), 32'd0);
    applyStimulus(2'b11, 8'h00);
    collect(3);
    checkOutput("stopEn",   enVec,   32'h0);
    checkOutput("stopBusy", busyVec, 32'h0);

    $display("[TB] SET_DIV 2 during RUN");
    applyStimulus(2'b11, 8'h03);
    applyStimulus(2'b01, 8'h02);
    collect(9);
    checkOutput("runDivEn",  enVec, 32'h0000_0248);
    checkOutput("runDivDir", 32'(ring_dir), 32'd1);
    applyStimulus(2'b11, 8'h00);

    $display("[TB] LOAD 0x00");
    applyStimulus(2'b00, 8'h00);
    @(negedge clk);
    checkOutput("zeroLoadVal", 32'(ring_load_val), 32'h01);
    checkOutput("zeroLoadErr", 32'(err),           32'd1);
    @(negedge clk);
    checkOutput("errSticky",   32'(err),           32'd1);
    applyStimulus(2'b01, 8'h02);
    @(negedge clk);
    checkOutput("errCleared",  32'(err),           32'd0);

    $display("[TB] reset mid-burst");
    applyStimulus(2'b00, 8'h3C);
    applyStimulus(2'b10, 8'h8A);
    collect(7);
    checkOutput("preRstEn", enVec, 32'h0000_0048);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy",    32'(busy),          32'd0);
    checkOutput("midRstEn",      32'(ring_en),       32'd0);
    checkOutput("midRstDir",     32'(ring_dir),      32'd0);
    checkOutput("midRstLoadVal", 32'(ring_load_val), 32'h01);
    checkOutput("midRstReady",   32'(cmd_ready),     32'd1);
    checkOutput("midRstDone",    32'(done),          32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    collect(30);
    checkOutput("postRstDone",  doneVec,  32'h0);
    checkOutput("postRstEn",    enVec,    32'h0);
    checkOutput("postRstReady", readyVec, 32'h7FFF_FFFE);
    applyStimulus(2'b11, 8'h01);
    collect(4);
    checkOutput("postRstDivZero", enVec, 32'h1E);
    applyStimulus(2'b11, 8'h00);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
